// File: rtl/ctrl_exposure_fsm_pkg.sv
// ctrl_exposure_fsm_pkg
//    Shared types and limits for the pixel exposure/readout sequencer.
//    The exposure-time control stage imports EXP_MIN/EXP_MAX from here,
//    so its range and the sequencer's clamp always agree.
package ctrl_exposure_fsm_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EXPOSURE = 2'd1,
      READOUT  = 2'd2
   } state_t;

   localparam int CNT_W = 5;

   localparam logic [CNT_W-1:0] EXP_MIN  = 5'd2;
   localparam logic [CNT_W-1:0] EXP_MAX  = 5'd30;
   localparam logic [CNT_W-1:0] READ_LEN = 5'd6;

   localparam logic [CNT_W-1:0] ADC_STEP_A = 5'd1;
   localparam logic [CNT_W-1:0] ADC_STEP_B = 5'd4;

   function automatic logic [CNT_W-1:0] clamp_exp(input logic [CNT_W-1:0] t);
      if (t < EXP_MIN)
         return EXP_MIN;
      else if (t > EXP_MAX)
         return EXP_MAX;
      else
         return t;
   endfunction

endpackage

// File: rtl/ctrl_cycle_counter.sv
// ctrl_cycle_counter
//    Loadable down-counter shared by the exposure and readout phases.
//    Ports:
//       clk      - system clock
//       rst_n    - synchronous active-low reset, clears the count
//       load     - load load_val (has priority over en)
//       en       - decrement by one
//       load_val - value to load
//       count    - current count
//       zero     - count is zero (terminal count)
module ctrl_cycle_counter
   import ctrl_exposure_fsm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && (count != '0))
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/ctrl_exposure_fsm.sv
// ctrl_exposure_fsm
//    Sequences one pixel capture: erase, timed exposure, two-row readout
//    with an ADC strobe per row.
//    Ports:
//       Clk     - system clock
//       Rst_n   - synchronous active-low reset
//       Init    - start one capture (sampled in IDLE only)
//       EX_time - exposure length in cycles, clamped to EXP_MIN..EXP_MAX
//       Erase   - pixel erase, active-high
//       Expose  - integrate enable, active-high
//       NRE_1   - row-1 read enable, active-low
//       NRE_2   - row-2 read enable, active-low
//       ADC     - ADC sample strobe, one cycle
//       Busy    - high outside IDLE
//
//    state    | meaning
//    ---------+------------------------------------------------------
//    IDLE     | pixel held in erase, waiting for Init
//    EXPOSURE | integrating; counter runs N-1 .. 0
//    READOUT  | step r = READ_LEN-1-count; row 1 at r<3, row 2 at r>=3
module ctrl_exposure_fsm
   import ctrl_exposure_fsm_pkg::*;
(
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Init,
   input  logic [CNT_W-1:0] EX_time,
   output logic             Erase,
   output logic             Expose,
   output logic             NRE_1,
   output logic             NRE_2,
   output logic             ADC,
   output logic             Busy
);

   localparam logic [CNT_W-1:0] ROW1_STEPS = READ_LEN >> 1;

   state_t           state, state_next;
   logic             cnt_load, cnt_en, cnt_zero;
   logic [CNT_W-1:0] cnt, cnt_load_val, step_next;
   logic             erase_next, expose_next, nre_1_next, nre_2_next;
   logic             adc_next, busy_next;

   // The counter also serves as the latched exposure value: EX_time is
   // captured into it on the Init edge and never looked at again.
   ctrl_cycle_counter u_cnt (
      .clk      (Clk),
      .rst_n    (Rst_n),
      .load     (cnt_load),
      .en       (cnt_en),
      .load_val (cnt_load_val),
      .count    (cnt),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_next   = state;
      cnt_load     = 1'b0;
      cnt_en       = 1'b0;
      cnt_load_val = '0;
      step_next    = '0;
      case (state)
         IDLE: begin
            if (Init) begin
               state_next   = EXPOSURE;
               cnt_load     = 1'b1;
               cnt_load_val = clamp_exp(EX_time) - 1'b1;
            end
         end
         EXPOSURE: begin
            if (cnt_zero) begin
               state_next   = READOUT;
               cnt_load     = 1'b1;
               cnt_load_val = READ_LEN - 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         READOUT: begin
            if (cnt_zero) begin
               state_next = IDLE;
            end else begin
               cnt_en = 1'b1;
               // step of the next cycle: current step (READ_LEN-1-cnt) plus one
               step_next = READ_LEN - cnt;
            end
         end
         default: state_next = IDLE;
      endcase

      // Outputs are decoded from the next state and registered below, so
      // they change on the same edge as the state they describe.
      erase_next  = (state_next == IDLE);
      expose_next = (state_next == EXPOSURE);
      busy_next   = (state_next != IDLE);
      nre_1_next  = !((state_next == READOUT) && (step_next <  ROW1_STEPS));
      nre_2_next  = !((state_next == READOUT) && (step_next >= ROW1_STEPS));
      adc_next    = (state_next == READOUT) &&
                    ((step_next == ADC_STEP_A) || (step_next == ADC_STEP_B));
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state  <= IDLE;
         Erase  <= 1'b1;
         Expose <= 1'b0;
         NRE_1  <= 1'b1;
         NRE_2  <= 1'b1;
         ADC    <= 1'b0;
         Busy   <= 1'b0;
      end else begin
         state  <= state_next;
         Erase  <= erase_next;
         Expose <= expose_next;
         NRE_1  <= nre_1_next;
         NRE_2  <= nre_2_next;
         ADC    <= adc_next;
         Busy   <= busy_next;
      end
   end

endmodule

// File: tb/tb_ctrl_exposure_fsm.sv
module tb_ctrl_exposure_fsm;

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic       Init = 1'b0;
   logic [4:0] EX_time = 5'd0;
   logic       Erase, Expose, NRE_1, NRE_2, ADC, Busy;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int expo;
      int nre1;
      int nre2;
      int adc;
      int mask;
      int busy;
      int gap;   // idle cycles before this capture; -1 = don't care
   } cap_t;

   cap_t sb[$];

   ctrl_exposure_fsm dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Init    (Init),
      .EX_time (EX_time),
      .Erase   (Erase),
      .Expose  (Expose),
      .NRE_1   (NRE_1),
      .NRE_2   (NRE_2),
      .ADC     (ADC),
      .Busy    (Busy)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   bit   mon_en = 0;
   bit   in_cap = 0;
   int   idle_cnt = 0;
   int   m_exp, m_nre1, m_nre2, m_adc, m_busy, m_gap, rd;
   logic [7:0] m_mask;
   cap_t e;

   always @(negedge Clk) begin
      if (mon_en) begin
         chk("nre_overlap", int'(!NRE_1 && !NRE_2), 0);
         chk("expose_conflict", int'(Expose && (!NRE_1 || !NRE_2 || Erase)), 0);
         if (!Busy)
            chk("idle_outputs", {Erase, Expose, NRE_1, NRE_2, ADC}, 5'b10110);
         if (Busy) begin
            if (!in_cap) begin
               in_cap = 1;
               m_gap  = idle_cnt;
               m_exp = 0; m_nre1 = 0; m_nre2 = 0; m_adc = 0; m_busy = 0;
               m_mask = '0;
            end
            m_busy++;
            if (Expose) m_exp++;
            if (!NRE_1) m_nre1++;
            if (!NRE_2) m_nre2++;
            if (ADC) begin
               m_adc++;
               rd = m_nre1 + m_nre2 - 1;
               if (rd >= 0 && rd < 6) m_mask[rd] = 1'b1;
               else m_mask[7] = 1'b1;
            end
         end else if (in_cap) begin
            in_cap   = 0;
            idle_cnt = 1;
            if (sb.size() == 0) begin
               chk("unexpected_capture", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("expose_len", m_exp, e.expo);
               chk("nre1_len", m_nre1, e.nre1);
               chk("nre2_len", m_nre2, e.nre2);
               chk("adc_count", m_adc, e.adc);
               chk("adc_steps", int'(m_mask), e.mask);
               chk("busy_len", m_busy, e.busy);
               if (e.gap >= 0) chk("idle_gap", m_gap, e.gap);
            end
         end else begin
            idle_cnt++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   task automatic push(input int expo, input int nre1, input int nre2, input int adc,
                       input int mask, input int busy, input int gap);
      cap_t c;
      c.expo = expo; c.nre1 = nre1; c.nre2 = nre2; c.adc = adc;
      c.mask = mask; c.busy = busy; c.gap = gap;
      sb.push_back(c);
   endtask

   task automatic pulse_init();
      Init = 1'b1;
      tick();
      Init = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      while (Busy !== 1'b0 && n < max_cyc) begin
         tick();
         n++;
      end
      if (Busy !== 1'b0) chk("wait_idle_timeout", 1, 0);
      tick();
   endtask

   task automatic check_idle_now(input string name);
      chk(name, {Erase, Expose, NRE_1, NRE_2, ADC, Busy}, 6'b101100);
   endtask

   task automatic sync_reset();
      Rst_n = 1'b0;
      tick();
      Rst_n = 1'b1;
   endtask

   localparam int FULL_MASK = 8'b0001_0010;

   initial begin
      int n;
      Rst_n = 1'b0;
      repeat (3) tick();
      check_idle_now("reset_state");
      Rst_n = 1'b1;
      tick();
      mon_en = 1;
      tick();

      // scenario 1: nominal capture, N=10
      EX_time = 5'd10;
      push(10, 3, 3, 2, FULL_MASK, 16, -1);
      pulse_init();
      chk("busy_after_init", int'(Busy), 1);
      chk("expose_after_init", int'(Expose), 1);
      chk("erase_after_init", int'(Erase), 0);
      wait_idle(60);

      // scenario 2: clamp at both ends
      EX_time = 5'd0;
      push(2, 3, 3, 2, FULL_MASK, 8, -1);
      pulse_init();
      wait_idle(60);
      EX_time = 5'd31;
      push(30, 3, 3, 2, FULL_MASK, 36, -1);
      pulse_init();
      wait_idle(60);
      EX_time = 5'd1;
      push(2, 3, 3, 2, FULL_MASK, 8, -1);
      pulse_init();
      wait_idle(60);

      // scenario 3: EX_time change mid-exposure, Init during readout
      EX_time = 5'd10;
      push(10, 3, 3, 2, FULL_MASK, 16, -1);
      pulse_init();
      repeat (3) tick();
      EX_time = 5'd25;
      n = 0;
      while (NRE_1 !== 1'b0 && n < 40) begin
         tick();
         n++;
      end
      if (NRE_1 !== 1'b0) chk("wait_readout_timeout", 1, 0);
      pulse_init();
      wait_idle(60);
      repeat (6) tick();
      chk("no_restart", int'(Busy), 0);

      // scenario 4a: reset at exposure cycle 5
      EX_time = 5'd10;
      push(5, 0, 0, 0, 0, 5, -1);
      pulse_init();
      repeat (4) tick();
      sync_reset();
      check_idle_now("abort_exposure");
      repeat (4) tick();

      // scenario 4b: reset at read step 2
      push(10, 3, 0, 1, 8'b0000_0010, 13, -1);
      pulse_init();
      repeat (12) tick();
      chk("at_read_step2", {NRE_1, NRE_2}, 2'b01);
      sync_reset();
      check_idle_now("abort_readout");
      repeat (6) tick();

      // scenario 5: Init held, back-to-back captures of 3+6
      EX_time = 5'd3;
      push(3, 3, 3, 2, FULL_MASK, 9, -1);
      push(3, 3, 3, 2, FULL_MASK, 9, 1);
      push(3, 3, 3, 2, FULL_MASK, 9, 1);
      Init = 1'b1;
      repeat (25) tick();
      Init = 1'b0;
      wait_idle(60);
      repeat (5) tick();

      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
